// File: rtl/pdm_pkg.sv
// ============================================================================
// Module      : pdm_pkg
// Description : Shared types and widths for the PDM record/playback block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_pkg;

  localparam int AMP_W = 7;
  localparam int PWM_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sample_ram.sv
// ============================================================================
// Module      : sample_ram
// Description : Simple dual-port sample RAM, registered read (latency 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_ram
  import pdm_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int WIDTH = AMP_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // No reset on the array or read register so the RAM maps onto block memory.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pdm_playback.sv
// ============================================================================
// Module      : pdm_playback
// Description : Records decimated microphone samples into RAM and plays them
//               back as a 7-bit PWM audio stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_playback
  import pdm_pkg::*;
#(
  parameter int CLK_FREQ = 100,
  parameter int DEPTH    = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AMP_W-1:0]         amplitude,
  input  logic                     amplitude_valid,
  input  logic                     start_record,
  input  logic                     start_play,
  input  logic                     stop,
  output logic                     recording,
  output logic                     playing,
  output logic [$clog2(DEPTH):0]   clip_len,
  output logic                     aud_pwm,
  output logic                     aud_sd
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CLK_FREQ < 1) begin : g_param_check
    $error("pdm_playback: DEPTH must be a power of two >= 2 and CLK_FREQ positive");
  end

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_rd_pend;
  logic             r_rd_last;
  logic             r_done;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [AMP_W-1:0] r_sample_reg;
  logic [AMP_W-1:0] w_rdata;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_rd_last;

  assign w_rd_last = (r_rd_ptr == (clip_len - 1'b1));

  always_comb begin
    w_next  = r_state;
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_record) begin
          w_next = RECORD;
        end else if (start_play && clip_len != '0) begin
          w_next = PLAY;
        end
      end
      RECORD: begin
        w_wr_en = amplitude_valid;
        if (stop || (amplitude_valid && r_wr_ptr == AW'(DEPTH - 1))) begin
          w_next = IDLE;
        end
      end
      PLAY: begin
        // Once every stored sample has been requested, further strobes are ignored.
        w_rd_en = amplitude_valid && !stop && (r_rd_ptr != clip_len);
        if (stop || r_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_last    <= 1'b0;
      r_done       <= 1'b0;
      r_pwm_cnt    <= '0;
      r_sample_reg <= '0;
      clip_len     <= '0;
      recording    <= 1'b0;
      playing      <= 1'b0;
      aud_sd       <= 1'b0;
      aud_pwm      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      recording <= (w_next == RECORD);
      playing   <= (w_next == PLAY);
      aud_sd    <= (w_next == PLAY);
      aud_pwm   <= (r_pwm_cnt < r_sample_reg);
      r_rd_pend <= w_rd_en;
      r_rd_last <= w_rd_en && w_rd_last;
      r_done    <= r_rd_pend && r_rd_last && (w_next == PLAY);

      if (r_state == IDLE && w_next == RECORD) begin
        r_wr_ptr <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (r_state == IDLE && w_next == PLAY) begin
        r_rd_ptr <= '0;
      end else if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      // Count includes a sample written on the exit cycle; a full buffer yields DEPTH.
      if (r_state == RECORD && w_next == IDLE) begin
        clip_len <= {1'b0, r_wr_ptr} + {{AW{1'b0}}, w_wr_en};
      end

      if (w_next == IDLE) begin
        r_sample_reg <= '0;
      end else if (r_rd_pend) begin
        r_sample_reg <= w_rdata;
      end
    end
  end

  sample_ram #(
    .DEPTH (DEPTH),
    .WIDTH (AMP_W)
  ) u_sample_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (amplitude),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_pdm_playback.sv
// ============================================================================
// Module      : tb_pdm_playback
// Description : Scoreboard bench for pdm_playback with a clip/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_playback;
  import pdm_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AMP_W-1:0] amplitude = '0;
  logic          amplitude_valid = 1'b0;
  logic          start_record = 1'b0;
  logic          start_play = 1'b0;
  logic          stop = 1'b0;
  logic          recording;
  logic          playing;
  logic [CW-1:0] clip_len;
  logic          aud_pwm;
  logic          aud_sd;

  always #5 clk = ~clk;

  pdm_playback #(
    .CLK_FREQ (100),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .amplitude       (amplitude),
    .amplitude_valid (amplitude_valid),
    .start_record    (start_record),
    .start_play      (start_play),
    .stop            (stop),
    .recording       (recording),
    .playing         (playing),
    .clip_len        (clip_len),
    .aud_pwm         (aud_pwm),
    .aud_sd          (aud_sd)
  );

  int total = 0;
  int bad   = 0;
  int exp_clip_q[$];
  int exp_samp_q[$];
  int mem_model [DEPTH];
  int clip_model = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; inputs are held across one posedge and then cleared.
  task automatic drive(input logic v, input int a, input logic sr, input logic sp, input logic st);
    amplitude_valid = v;
    amplitude       = 7'(a);
    start_record    = sr;
    start_play      = sp;
    stop            = st;
    @(negedge clk);
    amplitude_valid = 1'b0;
    start_record    = 1'b0;
    start_play      = 1'b0;
    stop            = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares clip length when recording ends and each loaded sample.
  logic prev_rec = 1'b0, prev_pend = 1'b0, prev_play = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_rec && !recording) begin
        if (exp_clip_q.size() == 0) begin
          total++; bad++;
          $display("FAIL clip_unexpected: got %0d expected no record end", clip_len);
        end else begin
          check("clip_len", int'(clip_len), exp_clip_q.pop_front());
        end
      end
      if (prev_pend) begin
        if (exp_samp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sample_unexpected: got %0d expected no load", dut.r_sample_reg);
        end else begin
          check("sample_reg", int'(dut.r_sample_reg), exp_samp_q.pop_front());
        end
      end
      check("aud_sd_eq_playing", int'(aud_sd), int'(playing));
      check("rec_play_exclusive", int'(recording && playing), 0);
      if (!playing && !prev_play) check("pwm_quiet", int'(aud_pwm), 0);
    end
    prev_rec  = recording;
    prev_pend = dut.r_rd_pend;
    prev_play = playing;
  end

  task automatic record_random();
    int n = 0;
    bit done = 0;
    drive(1'b0, 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("rnd_rec_start", int'(recording), 1);
    check("rnd_rec_noplay", int'(playing), 0);
    for (int c = 0; c < 200 && !done; c++) begin
      logic v;
      logic st;
      int a;
      v  = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 127);
      st = ($urandom_range(0, 11) == 0);
      if (v) begin
        mem_model[n] = a;
        n++;
      end
      if (n == DEPTH || st) begin
        exp_clip_q.push_back(n);
        clip_model = n;
        drive(v, a, 1'b0, 1'b0, st);
        check("rnd_rec_end", int'(recording), 0);
        done = 1;
      end else begin
        drive(v, a, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 1'b0);
      end
    end
    if (!done) begin
      exp_clip_q.push_back(n);
      clip_model = n;
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic play_random(input bit allow_stop);
    int k = 0;
    bit prev_v = 0;
    bit stopped = 0;
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    if (clip_model == 0) begin
      check("rnd_play_empty", int'(playing), 0);
      return;
    end
    check("rnd_play_start", int'(playing), 1);
    for (int c = 0; c < 300 && k < clip_model && !stopped; c++) begin
      logic v;
      if (allow_stop && !prev_v && $urandom_range(0, 9) == 0) begin
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("rnd_stop_playing", int'(playing), 0);
        check("rnd_stop_sd", int'(aud_sd), 0);
        stopped = 1;
      end else begin
        v = ($urandom_range(0, 2) == 0);
        if (v) begin
          exp_samp_q.push_back(mem_model[k]);
          k++;
        end
        drive(v, $urandom_range(0, 127), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 7) == 0), 1'b0);
        prev_v = v;
      end
    end
    if (!stopped && k < clip_model) begin
      idle(1);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      stopped = 1;
    end
    idle(3);
    check("rnd_play_over", int'(playing), 0);
    check("rnd_clip_hold", int'(clip_len), clip_model);
  endtask

  initial begin
    int hi;
    int vals[5] = '{10, 20, 30, 40, 50};

    // Reset state
    @(negedge clk);
    check("rst_recording", int'(recording), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_clip_len", int'(clip_len), 0);
    check("rst_aud_pwm", int'(aud_pwm), 0);
    check("rst_aud_sd", int'(aud_sd), 0);
    rst_n = 1'b1;
    idle(2);

    // Basic record of five samples
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("rec_started", int'(recording), 1);
    for (int i = 0; i < 5; i++) begin
      mem_model[i] = vals[i];
      drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    exp_clip_q.push_back(5);
    clip_model = 5;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("rec_fall_after_stop", int'(recording), 0);

    // Basic playback with duty-cycle measurement on the first sample
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("play_started", int'(playing), 1);
    check("play_sd", int'(aud_sd), 1);
    for (int i = 0; i < 5; i++) begin
      exp_samp_q.push_back(mem_model[i]);
      drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        idle(2);
        hi = 0;
        repeat (128) begin
          if (aud_pwm) hi++;
          idle(1);
        end
        check("duty_sample10", hi, 10);
      end else if (i == 4) begin
        idle(1);
        check("play_after_last_load", int'(playing), 1);
        idle(1);
        check("play_fell", int'(playing), 0);
        check("play_fell_sd", int'(aud_sd), 0);
      end else begin
        idle(3);
      end
    end
    check("clip_after_play", int'(clip_len), 5);

    // Conflicts
    drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("conflict_rec", int'(recording), 1);
    check("conflict_play", int'(playing), 0);
    exp_clip_q.push_back(0);
    clip_model = 0;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("empty_play_ignored", int'(playing), 0);
    idle(2);
    check("empty_play_idle", int'(playing) | int'(recording), 0);

    // Full buffer: 20 strobes, only the first DEPTH are kept
    begin
      int n = 0;
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
        int a;
        a = $urandom_range(0, 127);
        if (n < DEPTH) begin
          mem_model[n] = a;
          n++;
          if (n == DEPTH) exp_clip_q.push_back(DEPTH);
        end
        drive(1'b1, a, 1'b0, 1'b0, 1'b0);
        if (i == DEPTH - 1) check("full_idle", int'(recording), 0);
      end
      clip_model = DEPTH;
      check("full_clip", int'(clip_len), DEPTH);
      play_random(1'b0);
    end

    // Stop mid-play at sample 3
    begin
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        mem_model[i] = $urandom_range(1, 127);
        drive(1'b1, mem_model[i], 1'b0, 1'b0, 1'b0);
      end
      exp_clip_q.push_back(6);
      clip_model = 6;
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        exp_samp_q.push_back(mem_model[i]);
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
      end
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      check("stop_playing", int'(playing), 0);
      check("stop_sd", int'(aud_sd), 0);
      idle(1);
      check("stop_pwm", int'(aud_pwm), 0);
      check("stop_clip", int'(clip_len), 6);
    end

    // Asynchronous reset mid-record after 7 samples
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      mem_model[i] = $urandom_range(0, 127);
      drive(1'b1, mem_model[i], 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_recording", int'(recording), 0);
    check("arst_playing", int'(playing), 0);
    check("arst_clip", int'(clip_len), 0);
    check("arst_pwm", int'(aud_pwm), 0);
    check("arst_sd", int'(aud_sd), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clip_model = 0;
    idle(1);
    check("arst_clip_after", int'(clip_len), 0);

    // Randomized record/play sessions with idle-state strobes in between
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(1, 4)) drive(1'b1, $urandom_range(0, 127), 1'b0, 1'b0, 1'b0);
      check("idle_strobe_noeffect", int'(clip_len), clip_model);
      record_random();
      idle(1);
      play_random(1'b1);
    end

    idle(3);
    check("clip_q_drained", exp_clip_q.size(), 0);
    check("samp_q_drained", exp_samp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pdm_playback.md
PDM_PLAYBACK -- requirements
Module: pdm_playback

Interface
REQ-001 Parameter CLK_FREQ, default 100: system clock in MHz; informational only, no logic depends on it.
REQ-002 Parameter DEPTH, default 4096: sample memory depth in 7-bit words; SHALL be a power of two, at least 2.
REQ-003 clk  in  1  system clock, 100 MHz; the only clock in the block.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 amplitude  in  7  PDM-decimated microphone sample, value range 0..127.
REQ-006 amplitude_valid  in  1  one-cycle strobe marking amplitude as valid; also the playback pacing tick.
REQ-007 start_record  in  1  one-cycle pulse: begin capture from address 0.
REQ-008 start_play  in  1  one-cycle pulse: begin playback of the stored clip.
REQ-009 stop  in  1  one-cycle pulse: abort the current record or play.
REQ-010 recording  out  1  high while in RECORD.
REQ-011 playing  out  1  high while in PLAY.
REQ-012 clip_len  out  $clog2(DEPTH)+1  number of valid stored samples.
REQ-013 aud_pwm  out  1  PWM audio output.
REQ-014 aud_sd  out  1  amplifier enable, high only while playing.

Function
REQ-015 FSM states SHALL be IDLE, RECORD and PLAY; the reset state is IDLE.
REQ-016 IDLE -> RECORD on start_record: write pointer cleared to 0.
REQ-017 IDLE -> PLAY on start_play when clip_len != 0: read pointer cleared to 0.
REQ-018 start_play with clip_len == 0 SHALL be ignored; the FSM stays in IDLE.
REQ-019 If start_record and start_play arrive in the same cycle in IDLE, record SHALL win.
REQ-020 start_record and start_play SHALL be ignored in RECORD and in PLAY.
REQ-021 RECORD: each amplitude_valid writes amplitude to mem[wr_ptr], then wr_ptr increments by 1.
REQ-022 When the write to address DEPTH-1 occurs: clip_len <= DEPTH, then IDLE on the next cycle; no wrap-around and no overwrite.
REQ-023 stop in RECORD: clip_len <= wr_ptr (count of samples written), then IDLE.
- A valid sample coincident with stop SHALL be written and counted.
REQ-024 clip_len SHALL be updated only on leaving RECORD; it holds its value through PLAY and IDLE.
REQ-025 PLAY: on each amplitude_valid, issue a read of mem[rd_ptr]; the data returns 1 cycle later and loads the PWM sample register; rd_ptr increments.
REQ-026 After the read of address clip_len-1 completes and its sample is loaded, the FSM SHALL return to IDLE.
REQ-027 stop in PLAY: return to IDLE immediately, discarding any read in flight.
REQ-028 PWM generation:
- 7-bit free-running counter pwm_cnt.
- aud_pwm = (pwm_cnt < sample_reg), registered.
- sample 0 gives constant low; sample 127 gives 127/128 duty.
REQ-029 sample_reg SHALL be cleared to 0 on entering IDLE, so aud_pwm is low whenever not playing.
REQ-030 aud_sd SHALL equal playing, registered.
REQ-031 recording and playing SHALL be registered state decodes and never high together.
REQ-032 amplitude_valid outside RECORD and PLAY SHALL have no effect.

Reset
REQ-033 On rst_n low, the following SHALL clear asynchronously:
- FSM to IDLE.
- wr_ptr, rd_ptr, clip_len, sample_reg and pwm_cnt to 0.
- All outputs to 0.
REQ-034 Memory contents SHALL NOT be reset; a reset mid-record or mid-play SHALL abort the operation and leave clip_len = 0.

Structure
REQ-035 A shared package pdm_pkg SHALL hold:
- the state enum type (IDLE, RECORD, PLAY).
- AMP_W = 7 and PWM_W = 7.
REQ-036 Sub-module sample_ram SHALL be a simple dual-port RAM:
- one write port and one read port, width AMP_W, depth DEPTH.
- registered read, latency 1, no reset, BRAM-inferable.

Verification
REQ-037 Record basic: start_record, feed 5 valids with values 10, 20, 30, 40, 50, then stop -> clip_len = 5, recording falls 1 cycle after stop.
REQ-038 Playback: start_play after REQ-037, then 5 valid strobes.
- sample_reg steps through 10, 20, 30, 40, 50.
- aud_pwm is high for exactly 10 of each 128 cycles while the sample is 10.
- playing falls after the 5th sample loads.
REQ-039 Full buffer: DEPTH=16, record 20 valids -> clip_len = 16, FSM IDLE after the 16th write, mem[0..15] hold the first 16 values.
REQ-040 Conflicts:
- start_record and start_play pulsed together in IDLE -> recording = 1, playing = 0.
- start_play with clip_len = 0 -> no state change.
REQ-041 Stop mid-play at sample 3 -> playing = 0, aud_sd = 0, aud_pwm = 0 within 2 cycles; clip_len unchanged.
REQ-042 rst_n asserted mid-record after 7 samples -> all outputs 0 asynchronously; clip_len = 0 after release.
